carry_select_adder: RTL and testbench

//   WIDTH-bit unsigned/two's-complement adder with carry-in, using carry-select structure.

---
 rtl/carry_select_adder.sv | 73 +++++++
 tb/tb_carry_select_adder.sv | 120 ++++++++++++
 2 files changed

// File: rtl/carry_select_adder.sv
// Carry-select adder: {Cout,F} = A + B + Cin, built from BLOCK-bit groups.
// Latency 1 cycle, one op per cycle.
// No backpressure; every accepted operation yields one result.
module carry_select_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] F,
  output logic             Cout
);

  localparam int NG = WIDTH / BLOCK;

  if ((WIDTH % BLOCK) != 0 || WIDTH < BLOCK) begin : g_bad_cfg
    $error("carry_select_adder: WIDTH must be a nonzero multiple of BLOCK");
  end

  // Bit-serial ripple so each group really is a ripple chain, not a tool-chosen adder.
  function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] a,
                                            input logic [BLOCK-1:0] b,
                                            input logic             ci);
    logic             c;
    logic [BLOCK-1:0] s;
    c = ci;
    s = '0;
    for (int i = 0; i < BLOCK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  logic [NG:0]      carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = Cin;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    if (g == 0) begin : g_first
      assign {carry[1], sum[BLOCK-1:0]} = ripple(A[BLOCK-1:0], B[BLOCK-1:0], carry[0]);
    end else begin : g_sel
      logic [BLOCK:0] r0;
      logic [BLOCK:0] r1;
      assign r0 = ripple(A[g*BLOCK +: BLOCK], B[g*BLOCK +: BLOCK], 1'b0);
      assign r1 = ripple(A[g*BLOCK +: BLOCK], B[g*BLOCK +: BLOCK], 1'b1);
      // Lower group's carry picks the precomputed result.
      assign sum[g*BLOCK +: BLOCK] = carry[g] ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
      assign carry[g+1]            = carry[g] ? r1[BLOCK]     : r0[BLOCK];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      F         <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      F         <= sum;
      Cout      <= carry[NG];
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_carry_select_adder.sv
// Directed + random bench for carry_select_adder (WIDTH=32, BLOCK=4).
module tb_carry_select_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic        out_valid;
  logic [31:0] F;
  logic        Cout;

  int checks   = 0;
  int failures = 0;

  carry_select_adder #(.WIDTH(32), .BLOCK(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .out_valid(out_valid),
    .F        (F),
    .Cout     (Cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the capturing edge.
  task automatic cyc(input logic vld, input logic [31:0] a, input logic [31:0] b, input logic ci);
    @(negedge clk);
    in_valid = vld;
    A        = a;
    B        = b;
    Cin      = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic op_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic [31:0] ef, input logic ec);
    cyc(1'b1, a, b, ci);
    chk({tag, ".F"}, 64'(F), 64'(ef));
    chk({tag, ".Cout"}, 64'(Cout), 64'(ec));
    chk({tag, ".vld"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [32:0] gold;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    Cin      = 1'b0;

    // Reset held two cycles with a live operation that must be discarded.
    cyc(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    cyc(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    chk("rst.F", 64'(F), 64'd0);
    chk("rst.Cout", 64'(Cout), 64'd0);
    chk("rst.vld", 64'(out_valid), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;

    op_chk("sovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0);
    op_chk("novf",  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1);
    op_chk("mix1",  32'd100,       32'hFFFF_FFCE, 1'b0, 32'd50,        1'b1);
    op_chk("mix2",  32'd10,        32'd15,        1'b1, 32'd26,        1'b0);
    op_chk("mix3",  32'hFFFF_FFF6, 32'hFFFF_FFFB, 1'b1, 32'hFFFF_FFF2, 1'b1);
    op_chk("chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
    op_chk("wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);

    // Idle cycle: valid drops, result registers hold the last sum.
    cyc(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1);
    chk("idle.vld", 64'(out_valid), 64'd0);
    chk("idle.F", 64'(F), 64'd0);
    chk("idle.Cout", 64'(Cout), 64'd1);

    op_chk("b2b0", 32'd50,         32'd30,        1'b0, 32'd80,        1'b0);
    op_chk("b2b1", 32'hFFFF_FFE2,  32'hFFFF_FFEC, 1'b0, 32'hFFFF_FFCE, 1'b1);

    // Mid-stream reset drops the in-flight op.
    @(negedge clk);
    rst_n = 1'b0;
    cyc(1'b1, 32'h0F0F_0F0F, 32'h0101_0101, 1'b1);
    chk("rst2.F", 64'(F), 64'd0);
    chk("rst2.vld", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rc   = 1'($urandom_range(1, 0));
      gold = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      cyc(1'b1, ra, rb, rc);
      chk("rand.sum", 64'({Cout, F}), 64'(gold));
      chk("rand.vld", 64'(out_valid), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
